// File: rtl/fc_stream_pkg.sv
// Shared constants and types for the fc layer input streaming blocks.
package fc_stream_pkg;
  localparam int FC_N = 10;
  localparam int FC_T = 16;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fc_vec_bank.sv
// One N x T vector bank: indexed write port, combinational indexed read, full flag.
module fc_vec_bank
  import fc_stream_pkg::*;
#(
  parameter int N = FC_N,
  parameter int T = FC_T,
  localparam int IW = idx_w(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wr_en,
  input  logic [IW-1:0]       i_wr_idx,
  input  logic signed [T-1:0] i_wr_data,
  input  logic                i_set_full,
  input  logic                i_clr_full,
  input  logic [IW-1:0]       i_rd_idx,
  output logic signed [T-1:0] o_rd_data,
  output logic                o_full
);
  logic signed [T-1:0] r_mem [N];
  logic                r_full;

  // Contents are not reset; a full bank is never overwritten.
  always_ff @(posedge clk) begin
    if (i_wr_en && !r_full) r_mem[i_wr_idx] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_full <= 1'b0;
    else if (i_set_full) r_full <= 1'b1;
    else if (i_clr_full) r_full <= 1'b0;
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_full    = r_full;
endmodule

// File: rtl/fc_vec_tx.sv
// Double-buffered host-to-fc-layer vector streamer: fill one bank while the other transmits.
// state   | meaning
// TX_IDLE | no complete vector presented; waits for full[rd_bank]
// TX_SEND | presenting bank[rd_bank][rd_idx] to the fc layer
module fc_vec_tx
  import fc_stream_pkg::*;
#(
  parameter int N = FC_N,
  parameter int T = FC_T
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic signed [T-1:0] wr_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data,
  output logic                output_last,
  output logic [7:0]          vec_count
);
  localparam int IW = idx_w(N);

  tx_state_t           r_state;
  logic                r_wr_bank, r_rd_bank;
  logic [IW-1:0]       r_wr_idx, r_rd_idx;
  logic                r_out_valid, r_out_last;
  logic signed [T-1:0] r_out_data;
  logic [7:0]          r_vec_count;

  logic [1:0]          w_full;
  logic signed [T-1:0] w_rd_data [2];
  logic                w_wr_hs, w_wr_last, w_out_done;
  logic [IW-1:0]       w_rd_sel;

  assign wr_ready   = !w_full[r_wr_bank];
  assign w_wr_hs    = wr_valid && wr_ready;
  assign w_wr_last  = w_wr_hs && (r_wr_idx == IW'(N-1));
  assign w_out_done = r_out_valid && output_ready && r_out_last;
  // Look-ahead read index: word 0 on entry to TX_SEND, next word on each handshake.
  assign w_rd_sel   = (r_state == TX_SEND) ? r_rd_idx + IW'(1) : '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fc_vec_bank #(.N(N), .T(T)) u_bank (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (w_wr_hs && (r_wr_bank == 1'(b))),
      .i_wr_idx   (r_wr_idx),
      .i_wr_data  (wr_data),
      .i_set_full (w_wr_last && (r_wr_bank == 1'(b))),
      .i_clr_full (w_out_done && (r_rd_bank == 1'(b))),
      .i_rd_idx   (w_rd_sel),
      .o_rd_data  (w_rd_data[b]),
      .o_full     (w_full[b])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else if (w_wr_hs) begin
      if (w_wr_last) begin
        r_wr_idx  <= '0;
        r_wr_bank <= !r_wr_bank;
      end else begin
        r_wr_idx  <= r_wr_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= TX_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_vec_count <= '0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_full[r_rd_bank]) begin
            r_state     <= TX_SEND;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_data[r_rd_bank];
            r_out_last  <= (N == 1);
          end
        end
        TX_SEND: begin
          if (output_ready) begin
            if (r_out_last) begin
              r_state     <= TX_IDLE;
              r_rd_bank   <= !r_rd_bank;
              r_rd_idx    <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
              r_vec_count <= r_vec_count + 8'd1;
            end else begin
              r_rd_idx    <= w_rd_sel;
              r_out_data  <= w_rd_data[r_rd_bank];
              r_out_last  <= (w_rd_sel == IW'(N-1));
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign output_valid = r_out_valid;
  assign output_data  = r_out_data;
  assign output_last  = r_out_last;
  assign vec_count    = r_vec_count;
endmodule

// File: tb/tb_fc_vec_tx.sv
// Directed bench for fc_vec_tx: cycle table for a single vector plus streaming corner cases.
module tb_fc_vec_tx;
  import fc_stream_pkg::*;
  localparam int N = 10;
  localparam int T = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                wr_valid = 1'b0;
  logic signed [T-1:0] wr_data = '0;
  logic                output_ready = 1'b0;
  logic                wr_ready, output_valid, output_last;
  logic signed [T-1:0] output_data;
  logic [7:0]          vec_count;

  fc_vec_tx #(.N(N), .T(T)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .output_last(output_last), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic signed [T-1:0] q_data [$];
  int                  q_cyc  [$];
  logic                p_hold = 1'b0;
  logic signed [T-1:0] p_data;
  logic                p_last;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: records handshakes and checks that a stalled word holds.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        chk("hold_valid", output_valid, 1);
        chk("hold_data", output_data, p_data);
        chk("hold_last", output_last, p_last);
      end
      if (output_valid && output_ready) begin
        q_data.push_back(output_data);
        q_cyc.push_back(cyc);
      end
      p_hold = output_valid && !output_ready;
      p_data = output_data;
      p_last = output_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wr_valid = 1'b0;
    output_ready = 1'b0;
    repeat (2) tick();
    q_data.delete();
    q_cyc.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic write_word(input logic signed [T-1:0] d);
    int b;
    b = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && b < 500) begin
      b++;
      @(negedge clk);
    end
    if (!wr_ready) chk("wr_timeout", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_hs(input int cnt, input int budget);
    int b;
    b = 0;
    while (q_data.size() < cnt && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk("hs_count", q_data.size(), cnt);
  endtask

  typedef struct {
    logic                wv;
    logic signed [T-1:0] wd;
    logic                ordy;
    logic                e_wrdy;
    logic                e_ov;
    logic signed [T-1:0] e_od;
    logic                e_last;
    logic [7:0]          e_cnt;
  } vec_t;

  vec_t tv [22];
  logic signed [T-1:0] v3 [10];

  initial begin
    int errs;
    logic signed [T-1:0] e;

    // Cycle-by-cycle table: row i is driven after edge i and checked before edge i+1.
    for (int i = 0; i < 22; i++) begin
      tv[i] = '{wv: 1'b0, wd: '0, ordy: 1'b1, e_wrdy: 1'b1, e_ov: 1'b0, e_od: '0, e_last: 1'b0, e_cnt: 8'd0};
      if (i < 10) begin tv[i].wv = 1'b1; tv[i].wd = T'(i + 1); end
      if (i >= 11 && i <= 20) begin tv[i].e_ov = 1'b1; tv[i].e_od = T'(i - 10); tv[i].e_last = (i == 20); end
      if (i == 21) tv[i].e_cnt = 8'd1;
    end

    // Reset values, then one vector streamed with output_ready held high
    reset = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_valid", output_valid, 0);
    chk("rst_data", output_data, 0);
    chk("rst_last", output_last, 0);
    chk("rst_count", vec_count, 0);
    do_reset();
    for (int i = 0; i < 22; i++) begin
      wr_valid = tv[i].wv;
      wr_data = tv[i].wd;
      output_ready = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("t1_wr_ready[%0d]", i), wr_ready, tv[i].e_wrdy);
      chk($sformatf("t1_valid[%0d]", i), output_valid, tv[i].e_ov);
      chk($sformatf("t1_data[%0d]", i), output_data, tv[i].e_od);
      chk($sformatf("t1_last[%0d]", i), output_last, tv[i].e_last);
      chk($sformatf("t1_count[%0d]", i), vec_count, tv[i].e_cnt);
      tick();
    end
    wr_valid = 1'b0;

    // Three vectors against a stalled consumer; both banks fill
    do_reset();
    for (int w = 1; w <= 20; w++) write_word(T'(w));
    @(negedge clk);
    chk("t2_wr_ready_full", wr_ready, 0);
    chk("t2_valid", output_valid, 1);
    chk("t2_data_first", output_data, 1);
    chk("t2_last", output_last, 0);
    wr_valid = 1'b1;
    wr_data = T'(21);
    repeat (3) tick();
    @(negedge clk);
    chk("t2_wr_ready_held", wr_ready, 0);
    chk("t2_data_held", output_data, 1);
    output_ready = 1'b1;
    for (int w = 21; w <= 30; w++) write_word(T'(w));
    wait_hs(30, 2000);
    repeat (2) tick();
    chk("t2_count", vec_count, 3);
    for (int i = 0; i < 30 && i < q_data.size(); i++) chk($sformatf("t2_word[%0d]", i), q_data[i], i + 1);
    for (int i = 0; i < 29 && i + 1 < q_cyc.size(); i++)
      chk($sformatf("t2_gap[%0d]", i), q_cyc[i+1] - q_cyc[i], (i % 10 == 9) ? 2 : 1);

    // Extreme values with output_ready toggling every cycle
    v3 = '{16'sh8000, 16'sh7FFF, 16'sh0000, 16'sh0001, 16'shFFFF,
           16'sh0002, 16'shFFFE, 16'sh0064, 16'shFF9C, 16'sh3039};
    do_reset();
    fork
      for (int j = 0; j < 10; j++) write_word(v3[j]);
      begin
        int b;
        b = 0;
        while (q_data.size() < 10 && b < 2000) begin
          output_ready = (b % 2 == 0);
          tick();
          b++;
        end
      end
    join
    output_ready = 1'b1;
    wait_hs(10, 100);
    repeat (3) tick();
    chk("t3_count_words", q_data.size(), 10);
    for (int i = 0; i < 10 && i < q_data.size(); i++) chk($sformatf("t3_word[%0d]", i), q_data[i], v3[i]);
    chk("t3_vec_count", vec_count, 1);

    // Host gaps of two cycles: nothing leaves until the tenth word
    do_reset();
    output_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      write_word(T'(200 + j));
      if (j < 9) begin
        repeat (2) begin
          @(negedge clk);
          chk($sformatf("t4_idle[%0d]", j), output_valid, 0);
          tick();
        end
      end
    end
    @(negedge clk);
    chk("t4_valid_k", output_valid, 0);
    tick();
    @(negedge clk);
    chk("t4_valid_k1", output_valid, 1);
    chk("t4_data_k1", output_data, 200);
    wait_hs(10, 100);
    for (int i = 0; i < 10 && i < q_data.size(); i++) chk($sformatf("t4_word[%0d]", i), q_data[i], 200 + i);

    // Reset in the middle of a vector with a partial vector pending
    do_reset();
    output_ready = 1'b1;
    for (int j = 1; j <= 10; j++) write_word(T'(j));
    wait_hs(10, 100);
    q_data.delete();
    q_cyc.delete();
    repeat (2) tick();
    chk("t5_count_pre", vec_count, 1);
    for (int j = 51; j <= 63; j++) write_word(T'(j));
    wait_hs(5, 100);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_valid_rst", output_valid, 0);
    chk("t5_data_rst", output_data, 0);
    chk("t5_last_rst", output_last, 0);
    chk("t5_count_rst", vec_count, 0);
    chk("t5_wr_ready_rst", wr_ready, 1);
    tick();
    q_data.delete();
    q_cyc.delete();
    reset = 1'b1;
    tick();
    chk("t5_wr_ready_post", wr_ready, 1);
    for (int j = 100; j <= 109; j++) write_word(T'(j));
    wait_hs(10, 100);
    repeat (15) tick();
    chk("t5_words", q_data.size(), 10);
    for (int i = 0; i < 10 && i < q_data.size(); i++) chk($sformatf("t5_word[%0d]", i), q_data[i], 100 + i);
    chk("t5_count", vec_count, 1);

    // 256 vectors: vec_count wraps on the last final handshake
    do_reset();
    output_ready = 1'b1;
    fork
      for (int v = 0; v < 256; v++)
        for (int j = 0; j < 10; j++) write_word(T'(v * 10 + j));
      begin
        wait_hs(2550, 40000);
        repeat (2) tick();
        chk("t6_count_255", vec_count, 255);
        wait_hs(2560, 1000);
        repeat (2) tick();
        chk("t6_count_wrap", vec_count, 0);
      end
    join
    errs = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      e = T'(i);
      if (q_data[i] !== e) errs++;
    end
    chk("t6_order_errs", errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fc_vec_tx.md
FC_VEC_TX -- requirements
Module: fc_vec_tx

Interface
REQ-001 Parameter N, default 10, meaning words per input vector (fc layer N).
REQ-002 Parameter T, default 16, meaning signed word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  host word available.
REQ-006 wr_ready  output  1  block can accept a host word.
REQ-007 wr_data  input  T  signed host word, vector element order 0..N-1.
REQ-008 output_valid  output  1  word presented to fc layer input (connects to its input_valid).
REQ-009 output_ready  input  1  fc layer accepts word (connects to its input_ready).
REQ-010 output_data  output  T  signed word to fc layer input_data.
REQ-011 output_last  output  1  high with element N-1 of a vector.
REQ-012 vec_count  output  8  number of vectors fully transmitted, modulo 256.

Function
REQ-013 Storage SHALL be two banks (0,1) of N x T registers, each with a full flag.
REQ-014 Write side: wr_bank pointer and wr_idx counter (0..N-1); wr_ready SHALL equal NOT full[wr_bank].
REQ-015 Write handshake (wr_valid & wr_ready) SHALL store wr_data at bank[wr_bank][wr_idx] and increment wr_idx.
REQ-016 Handshake at wr_idx=N-1 SHALL set full[wr_bank], wrap wr_idx to 0, toggle wr_bank, all on the same edge.
REQ-017 Transmit FSM states: TX_IDLE, TX_SEND; rd_bank pointer and rd_idx counter (0..N-1).
REQ-018 TX_IDLE -> TX_SEND when full[rd_bank]=1; rd_idx=0 on entry.
REQ-019 In TX_SEND output_valid=1, output_data=bank[rd_bank][rd_idx], output_last=(rd_idx==N-1); in TX_IDLE all three are 0.
REQ-020 output_data and output_last SHALL hold stable while output_valid & !output_ready.
REQ-021 Output handshake (output_valid & output_ready) SHALL increment rd_idx.
REQ-022 Handshake with output_last=1 SHALL clear full[rd_bank], toggle rd_bank, wrap rd_idx, increment vec_count (255 wraps to 0), and go to TX_IDLE.
REQ-023 Latency: final host word accepted at edge k -> output_valid=1 in cycle k+1 when FSM is idle; back-to-back vectors SHALL incur exactly one idle cycle between last and first words.
REQ-024 Simultaneous fill of one bank and release of the other on the same edge SHALL both take effect.
REQ-025 Both banks full: wr_ready=0; host words SHALL be ignored until a bank is released; the released bank's wr_ready SHALL rise the cycle after release.
REQ-026 A bank SHALL never be written while full; output_data words SHALL exit in exactly host write order.
REQ-027 wr_valid low mid-vector SHALL pause filling without loss; partial vectors SHALL never be transmitted.
REQ-028 output_ready SHALL be honoured whether it arrives before, with, or after output_valid.

Reset
REQ-029 Reset asserted SHALL immediately force: FSM=TX_IDLE, both full flags 0, wr_bank=rd_bank=0, wr_idx=rd_idx=0, vec_count=0, output_valid=0, output_last=0, output_data=0.
REQ-030 wr_ready SHALL read 1 while reset is asserted and after deassertion (bank 0 empty).
REQ-031 Bank contents need not be reset; reset mid-vector SHALL discard partial and pending vectors.

Structure
REQ-032 Shared package fc_stream_pkg SHALL hold default N, T constants and the tx_state_t enum (TX_IDLE, TX_SEND).
REQ-033 One sub-module fc_vec_bank (N x T register bank, write port, indexed read, full flag with set/clear) SHALL be instantiated twice.

Verification
REQ-034 Reset, then 10 words 1..10 with output_ready=1 -> output_data 1..10 in consecutive cycles, output_last on 10, vec_count=1.
REQ-035 Host writes 3 vectors (1..10, 11..20, 21..30) with output_ready=0 -> wr_ready falls after word 20, output_valid=1 holding data 1; then ready=1 -> 1..30 in order, vec_count=3.
REQ-036 output_ready toggled 1010... on a vector of -32768,32767,0,... -> each word held stable until accepted, no duplication or loss.
REQ-037 wr_valid gaps of 2 cycles after every word -> no output_valid until 10th word; output then starts next cycle.
REQ-038 Assert reset after 5 output handshakes of a vector -> outputs 0 immediately, vec_count=0, wr_ready=1; fresh vector 100..109 transmits intact.
REQ-039 Send 256 vectors -> vec_count wraps to 0 after the 256th final handshake.
